// File: rtl/product_uart_rx.sv
// -----------------------------------------------------------------------------
// product_uart_rx
//   Serial receiver for the multiplier's 8N1 `tx` line. It recovers the 8-bit
//   signed product, LSB first, and reports each frame with a one-cycle pulse.
//   The whole receiver runs in the CLK domain. The raw line passes through a
//   2-flop synchroniser (rx_s) before any logic sees it.
//
//   Optional feature, macro PRODUCT_UART_RX_PARITY_EN:
//     When defined, one even-parity bit follows the data bits.
//     When undefined, the frame is 10 bits and parity_err is tied low.
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per serial bit (>= 4, must match the transmitter)
//   HALF_BIT     : cycles from start-edge detect to the start-bit mid-sample
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   rx         in   serial line, idle high
//   rx_data    out  last good received byte
//   rx_valid   out  one-cycle pulse; rx_data updated this cycle
//   frame_err  out  one-cycle pulse; stop bit sampled low
//   parity_err out  one-cycle pulse; parity mismatch (parity build only)
//   busy       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module product_uart_rx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PRODUCT_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    logic          rx_meta, rx_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;
`ifdef PRODUCT_UART_RX_PARITY_EN
    logic          par_bit, par_n, perr_n;
`endif

    // The synchroniser flops reset to the idle level. This keeps the line from
    // looking like a start bit right after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments, so rx_s takes the old rx_meta and this is a real 2-stage chain.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef PRODUCT_UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shift     <= shift_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
`ifdef PRODUCT_UART_RX_PARITY_EN
            par_bit    <= par_n;
            parity_err <= perr_n;
`endif
        end
    end

    always_comb begin
        // NOTE: every next value gets a default first, so no branch can leave one unassigned and infer a latch.
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef PRODUCT_UART_RX_PARITY_EN
        par_n   = par_bit;
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    if (!rx_s) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        bit_n   = '0;
                    end else begin
                        // The line went high again before mid-start: treat it as a glitch.
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_n[bit_idx] = rx_s;
                    cnt_n            = '0;
                    if (bit_idx == 3'd7) begin
`ifdef PRODUCT_UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef PRODUCT_UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    par_n   = rx_s;
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        // A bad stop bit is reported only as a frame error,
                        // even when the parity is also wrong.
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end else begin
                        // Returning to IDLE here lets a start bit that
                        // immediately follows this stop bit be caught.
                        state_n = IDLE;
`ifdef PRODUCT_UART_RX_PARITY_EN
                        if (par_bit != ^shift) begin
                            perr_n = 1'b1;
                        end else begin
                            data_n  = shift;
                            valid_n = 1'b1;
                        end
`else
                        data_n  = shift;
                        valid_n = 1'b1;
`endif
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BREAK: begin
                // Stay here while the line is held low, so a long break
                // reports only one frame_err.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifndef PRODUCT_UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_product_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_product_uart_rx
//   Self-checking bench for product_uart_rx with CLKS_PER_BIT = 4.
//
//   A monitor logs every output pulse with its cycle number and the rx_data
//   value at that time. Each group of frames is then compared with an
//   expected event list. That list comes from one of two sources:
//     - a table of vectors that holds literal expected results, or
//     - a frame-level model, which applies the receiver rules to each whole
//       frame.
// -----------------------------------------------------------------------------
module tb_product_uart_rx;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;
`ifdef PRODUCT_UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // A pulse appears in the cycle that follows edge 3 + HALF + (NBITS-1)*CPB,
    // where edge 1 is the first edge to see the start bit at the pin.
    // Expressed relative to the cycle number of edge 1, that offset is LAT.
    localparam int LAT = 2 + HALF + (NBITS - 1) * CPB;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, busy;

    product_uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        int         kind;   // 0 = rx_valid, 1 = frame_err, 2 = parity_err
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       exp_valid;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    ev_t        got_q[$];
    ev_t        exp_q[$];
    logic [7:0] model_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Event monitor: samples 1 time unit after each rising edge.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        #1;
        if ((rx_valid | frame_err | parity_err) !== 1'b0) begin
            check("pulse_exclusive", 32'($countones({rx_valid, frame_err, parity_err})), 32'd1);
            if (rx_valid)   got_q.push_back('{cyc, 0, rx_data});
            if (frame_err)  got_q.push_back('{cyc, 1, rx_data});
            if (parity_err) got_q.push_back('{cyc, 2, rx_data});
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Must be entered on a falling edge. On return, rx is still at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                              output int start);
        start = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef PRODUCT_UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    // Frame-level reference: what the receiver must report for a whole frame.
    task automatic model_frame(input int start, input logic [7:0] d, input logic stop,
                               input logic par);
        logic par_ok;
        par_ok = 1'b1;
`ifdef PRODUCT_UART_RX_PARITY_EN
        par_ok = (par == ^d);
`endif
        if (!stop)
            exp_q.push_back('{start + LAT, 1, model_data});
        else if (!par_ok)
            exp_q.push_back('{start + LAT, 2, model_data});
        else begin
            model_data = d;
            exp_q.push_back('{start + LAT, 0, d});
        end
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_cycle"}, got_q[i].cyc, exp_q[i].cyc);
            check({tag, "_kind"},  got_q[i].kind, exp_q[i].kind);
            check({tag, "_data"},  {24'd0, got_q[i].data}, {24'd0, exp_q[i].data});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"},    {24'd0, rx_data}, 32'h00);
        check({tag, "_rx_valid"},   {31'd0, rx_valid}, 32'd0);
        check({tag, "_frame_err"},  {31'd0, frame_err}, 32'd0);
        check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
        check({tag, "_busy"},       {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec_t       tbl[7];
        int         s;
        logic       seen;
        logic [7:0] d;
        logic       stop, par;

        tbl[0] = '{8'hF2, 1'b1, 0, 1'b1, 1'b0, 8'hF2};  // 7 * -2, followed immediately by the next frame
        tbl[1] = '{8'hFE, 1'b1, 8, 1'b1, 1'b0, 8'hFE};  // -1 * 2, sent back-to-back
        tbl[2] = '{8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 3, 1'b1, 1'b0, 8'hFF};
        tbl[4] = '{8'h81, 1'b0, 8, 1'b0, 1'b1, 8'hFF};  // bad stop, so rx_data holds
        tbl[5] = '{8'h7F, 1'b1, 1, 1'b1, 1'b0, 8'h7F};
        tbl[6] = '{8'h80, 1'b1, 5, 1'b1, 1'b0, 8'h80};

        // Power-on reset.
        RST = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check_reset_outputs("reset");
        idle(4);
        got_q.delete();

        // Table of vectors.
        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].stop, ^tbl[i].data, s);
            if (tbl[i].exp_valid)
                exp_q.push_back('{s + LAT, 0, tbl[i].exp_data});
            else if (tbl[i].exp_ferr)
                exp_q.push_back('{s + LAT, 1, tbl[i].exp_data});
            idle(tbl[i].gap);
        end
        idle(12);
        compare_events("table");
        model_data = 8'h80;

        // One-cycle low glitch on an idle line.
        rx = 1'b0;
        @(negedge CLK);
        rx   = 1'b1;
        seen = busy;
        for (int i = 2; i <= HALF + 3; i++) begin
            @(negedge CLK);
            seen = seen | busy;
        end
        check("glitch_busy_seen",  {31'd0, seen}, 32'd1);
        check("glitch_busy_clear", {31'd0, busy}, 32'd0);
        idle(20);
        compare_events("glitch");

        // Bad stop bit, line held low for 40 cycles, then a normal frame.
        send_frame(8'h55, 1'b0, ^8'h55, s);
        model_frame(s, 8'h55, 1'b0, ^8'h55);
        repeat (40 - CPB) @(negedge CLK);
        idle(8);
        send_frame(8'h0C, 1'b1, ^8'h0C, s);
        model_frame(s, 8'h0C, 1'b1, ^8'h0C);
        idle(12);
        compare_events("break");

        // Reset pulse during data bit 4 of 8'hA5. The sender abandons the
        // frame at the same time.
        d = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        rx  = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_data = 8'h00;
        check_reset_outputs("midframe_reset");
        idle(60);
        compare_events("midframe_reset");
        send_frame(8'h3C, 1'b1, ^8'h3C, s);
        model_frame(s, 8'h3C, 1'b1, ^8'h3C);
        idle(12);
        compare_events("post_reset");

`ifdef PRODUCT_UART_RX_PARITY_EN
        // 8'h07 has three ones: parity bit 0 is wrong, parity bit 1 is right.
        send_frame(8'h07, 1'b1, 1'b0, s);
        model_frame(s, 8'h07, 1'b1, 1'b0);
        idle(6);
        send_frame(8'h07, 1'b1, 1'b1, s);
        model_frame(s, 8'h07, 1'b1, 1'b1);
        idle(12);
        compare_events("parity");
`endif

        // Randomised frames: random data, occasional bad stop bits and
        // wrong parity, and random idle gaps (zero allowed after a good stop).
        for (int n = 0; n < 30; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, stop, par, s);
            model_frame(s, d, stop, par);
            idle(stop ? int'($urandom_range(0, 5)) : int'($urandom_range(4, 9)));
        end
        idle(12);
        compare_events("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_uart_rx.md
Name: product_uart_rx

Overview:
- Serial receiver that is the far end of the multiplier's `tx` line.
- Deserialises 8N1 frames (idle high, LSB first) carrying the 8-bit signed product back into a parallel byte, plus a one-cycle valid strobe and error flags.
- Sits on the bench/host side of the serial link, clocked by the same CLK domain.

Parameters:
- CLKS_PER_BIT, 4, CLK cycles per serial bit; must be ≥4 and must match the transmitter.
- HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detect to the start-bit mid-sample.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- rx  input  1  serial line; idle = 1.
- rx_data  output  8  last good received byte (product, two's complement).
- rx_valid  output  1  one-cycle pulse; rx_data updated this cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled 0.
- parity_err  output  1  one-cycle pulse; parity mismatch (see Optional Feature).
- busy  output  1  high in every state except IDLE.

Behaviour:
- One clock, CLK.
- Reset is synchronous and active-high on RST: sampled on the CLK rising edge, with priority over all other logic.
- Reset values:
  - rx_data=8'h00; rx_valid=0; frame_err=0; parity_err=0; busy=0.
  - Both synchroniser flops = 1.
  - State = IDLE; bit counter = 0; cycle counter = 0.
- rx input synchronisation: passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
- State machine: IDLE, START, DATA, (PARITY), STOP, BREAK.
- IDLE: on rx_s==0 go to START and clear the cycle counter.
- START: count cycles. At count HALF_BIT-1, sample rx_s:
  - 0: go to DATA, clear counter and bit index.
  - 1: glitch; return to IDLE with no output pulse.
- DATA:
  - Every CLKS_PER_BIT cycles (count==CLKS_PER_BIT-1), sample rx_s into shift[bit_index], LSB first, and clear the counter.
  - After bit 7, go to STOP (or PARITY when enabled).
- STOP: at count==CLKS_PER_BIT-1, sample rx_s:
  - 1: rx_data<=shift, rx_valid=1 for exactly one cycle, go to IDLE.
  - 0: frame_err=1 for one cycle, rx_data unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line produces exactly one frame_err.
- Latency: edge 1 is the first CLK edge sampling rx=0 at the pin. rx_valid is high in the cycle following edge 3+HALF_BIT+9*CLKS_PER_BIT (+CLKS_PER_BIT with parity).
- Back-to-back frames: a new start bit immediately after the stop bit must be caught. IDLE is entered the cycle after the stop sample, so zero idle bits between frames are supported.
- Reset mid-frame: partial byte discarded, no pulses, rx_data holds 8'h00.
- rx_valid, frame_err and parity_err are mutually exclusive in any cycle.

Optional Feature:
- Macro: PRODUCT_UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state after DATA; one even-parity bit is sampled at the same bit timing.
  - On mismatch with ^shift: parity_err pulses one cycle at the stop-bit sample, rx_valid stays 0 and rx_data is unchanged. This applies only if the stop bit is 1; a 0 stop bit reports frame_err only.
- Undefined:
  - No PARITY state; frame = 10 bits.
  - parity_err tied to 0.

Test Plan:
- CLKS_PER_BIT=4, send 8'hF2 (7 × -2 = -14) as 8N1 → rx_valid single pulse at the specified edge, rx_data=8'hF2, frame_err=0.
- Send 8'hFE (-1 × 2) immediately after 8'hF2 with no idle bits → two rx_valid pulses, rx_data 8'hF2 then 8'hFE.
- 1-cycle low glitch on idle rx → no rx_valid, no frame_err, busy returns to 0 within HALF_BIT+3 cycles.
- Send 8'h55 with stop bit = 0, then hold rx low for 40 cycles, then high → exactly one frame_err pulse, rx_data unchanged, then 8'h0C received normally.
- Assert RST for one cycle during data bit 4 of 8'hA5 → all outputs at reset values, that frame yields no rx_valid; next frame 8'h3C received correctly.
- With PRODUCT_UART_RX_PARITY_EN: send 8'h07 with parity bit 0 (wrong) → parity_err pulse, no rx_valid; send 8'h07 with parity 1 → rx_valid, rx_data=8'h07.
